// File: rtl/frame_buffer_writer_pkg.sv
// ----------------------------------------------------------------------------
// frame_buffer_writer_pkg
// Shared definitions for the frame buffer write path and the HDMI compositor:
// image geometry, per-bank RAM address width, RGB field offsets inside a
// 24-bit pixel word, and the writer FSM state encoding.
// ----------------------------------------------------------------------------
package frame_buffer_writer_pkg;

    localparam int IMG_WIDTH  = 224;
    localparam int IMG_HEIGHT = 224;
    localparam int ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int X_W        = $clog2(IMG_WIDTH);
    localparam int Y_W        = $clog2(IMG_HEIGHT);

    // Pixel word layout {R, G, B}
    localparam int PIX_W     = 24;
    localparam int RGB_CH_W  = 8;
    localparam int RGB_R_LSB = 16;
    localparam int RGB_G_LSB = 8;
    localparam int RGB_B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DROP  = 2'd2,
        ST_FULL  = 2'd3
    } fbw_state_e;

endpackage

// File: rtl/fbw_pingpong_ctrl.sv
// ----------------------------------------------------------------------------
// fbw_pingpong_ctrl
// Owns the ping-pong bank selection. The writer fills wr_bank while the
// compositor reads rd_bank; the two swap only when a complete frame is waiting
// (writer in FULL) and the display frame-start strobe arrives.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   i_state      in   current writer FSM state
//   i_frame_strb in   display frame-start pulse
//   o_swap       out  swap happens at this edge (FULL -> IDLE handshake)
//   o_wr_bank    out  bank being written
//   o_rd_bank    out  bank the compositor reads
// ----------------------------------------------------------------------------
module fbw_pingpong_ctrl
    import frame_buffer_writer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  fbw_state_e i_state,
    input  logic       i_frame_strb,
    output logic       o_swap,
    output logic       o_wr_bank,
    output logic       o_rd_bank
);

    logic r_wr_bank;
    logic r_rd_bank;

    // A strobe outside FULL is ignored, so a half-written bank is never shown.
    assign o_swap = (i_state == ST_FULL) && i_frame_strb;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank <= 1'b1;
            r_rd_bank <= 1'b0;
        end else if (o_swap) begin
            r_rd_bank <= r_wr_bank;
            r_wr_bank <= ~r_wr_bank;
        end
    end

    assign o_wr_bank = r_wr_bank;
    assign o_rd_bank = r_rd_bank;

endmodule

// File: rtl/frame_buffer_writer.sv
// ----------------------------------------------------------------------------
// frame_buffer_writer
// Frames an RGB pixel stream into IMG_WIDTH x IMG_HEIGHT and writes it into a
// ping-pong RAM. Writes are registered (one cycle after acceptance), one beat
// per clock. Malformed lines and mid-frame SOFs raise sticky error flags but
// never stall the stream.
// Ports:
//   pixel_clk, rst            clock, synchronous active-high reset
//   s_valid/s_ready/s_data    pixel stream handshake and {R,G,B} payload
//   s_sof, s_eol              first pixel of frame, last pixel of line
//   frame_strb                display frame-start pulse (bank swap trigger)
//   wr_en/wr_bank/wr_addr/wr_data   RAM write port; address {wr_bank, wr_addr}
//   rd_bank                   bank the compositor reads
//   frame_done                pulse with the final write of a complete frame
//   err_sof, err_line         sticky protocol error flags
// ----------------------------------------------------------------------------
module frame_buffer_writer
    import frame_buffer_writer_pkg::*;
(
    input  logic              pixel_clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_sof,
    input  logic              s_eol,
    input  logic              frame_strb,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              rd_bank,
    output logic              frame_done,
    output logic              err_sof,
    output logic              err_line
);

    fbw_state_e        r_state;
    logic              r_s_ready;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [PIX_W-1:0]  r_wr_data;
    logic              r_frame_done;
    logic              r_err_sof;
    logic              r_err_line;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [ADDR_W-1:0] r_row_base;

    fbw_state_e        w_next_state;
    logic              w_accept;
    logic              w_swap;
    logic              w_take;
    logic [X_W-1:0]    w_x_eff;
    logic [Y_W-1:0]    w_y_eff;
    logic [ADDR_W-1:0] w_base_eff;
    logic              w_x_last;
    logic              w_y_last;
    logic [X_W-1:0]    w_x_nxt;
    logic [Y_W-1:0]    w_y_nxt;
    logic [ADDR_W-1:0] w_base_nxt;
    logic              w_wr_en_nxt;
    logic [ADDR_W-1:0] w_wr_addr_nxt;
    logic [PIX_W-1:0]  w_wr_data_nxt;
    logic              w_done_nxt;
    logic              w_err_sof_set;
    logic              w_err_line_set;

    fbw_pingpong_ctrl u_pingpong (
        .clk          (pixel_clk),
        .rst          (rst),
        .i_state      (r_state),
        .i_frame_strb (frame_strb),
        .o_swap       (w_swap),
        .o_wr_bank    (wr_bank),
        .o_rd_bank    (rd_bank)
    );

    assign w_accept = s_valid && r_s_ready;

    // An SOF beat always restarts at the frame origin, whatever the counters say.
    assign w_x_eff    = s_sof ? '0 : r_x;
    assign w_y_eff    = s_sof ? '0 : r_y;
    assign w_base_eff = s_sof ? '0 : r_row_base;
    assign w_x_last   = (w_x_eff == X_W'(IMG_WIDTH - 1));
    assign w_y_last   = (w_y_eff == Y_W'(IMG_HEIGHT - 1));

    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        w_next_state   = r_state;
        w_take         = 1'b0;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_base_nxt     = r_row_base;
        w_wr_en_nxt    = 1'b0;
        w_wr_addr_nxt  = r_wr_addr;
        w_wr_data_nxt  = r_wr_data;
        w_done_nxt     = 1'b0;
        w_err_sof_set  = 1'b0;
        w_err_line_set = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_take = w_accept && s_sof;
            end
            ST_WRITE: begin
                w_take        = w_accept;
                w_err_sof_set = w_accept && s_sof;
            end
            ST_DROP: begin
                if (w_accept && s_sof) begin
                    w_take        = 1'b1;
                    w_err_sof_set = 1'b1;
                end else if (w_accept && s_eol) begin
                    // End of the overlong line: resume at the next row.
                    if (w_y_last) begin
                        w_next_state = ST_FULL;
                        w_x_nxt      = '0;
                        w_y_nxt      = '0;
                        w_base_nxt   = '0;
                    end else begin
                        w_next_state = ST_WRITE;
                        w_x_nxt      = '0;
                        w_y_nxt      = r_y + Y_W'(1);
                        w_base_nxt   = r_row_base + ADDR_W'(IMG_WIDTH);
                    end
                end
            end
            ST_FULL: begin
                if (w_swap) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (w_take) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = w_base_eff + ADDR_W'(w_x_eff);
            w_wr_data_nxt = s_data;
            w_next_state  = ST_WRITE;
            w_y_nxt       = w_y_eff;
            w_base_nxt    = w_base_eff;
            if (w_x_last && w_y_last) begin
                w_done_nxt   = 1'b1;
                w_next_state = ST_FULL;
                w_x_nxt      = '0;
                w_y_nxt      = '0;
                w_base_nxt   = '0;
            end else if (s_eol) begin
                // A short line leaves its remainder unwritten.
                w_err_line_set = !w_x_last;
                w_x_nxt        = '0;
                if (w_y_last) begin
                    w_next_state = ST_FULL;
                    w_y_nxt      = '0;
                    w_base_nxt   = '0;
                end else begin
                    w_y_nxt    = w_y_eff + Y_W'(1);
                    w_base_nxt = w_base_eff + ADDR_W'(IMG_WIDTH);
                end
            end else if (w_x_last) begin
                // Line full but no eol: discard until the line ends.
                w_err_line_set = 1'b1;
                w_next_state   = ST_DROP;
                w_x_nxt        = '0;
            end else begin
                w_x_nxt = w_x_eff + X_W'(1);
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_s_ready    <= 1'b1;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_frame_done <= 1'b0;
            r_err_sof    <= 1'b0;
            r_err_line   <= 1'b0;
            r_x          <= '0;
            r_y          <= '0;
            r_row_base   <= '0;
        end else begin
            r_state      <= w_next_state;
            r_s_ready    <= (w_next_state != ST_FULL);
            r_wr_en      <= w_wr_en_nxt;
            r_wr_addr    <= w_wr_addr_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_frame_done <= w_done_nxt;
            r_err_sof    <= r_err_sof | w_err_sof_set;
            r_err_line   <= r_err_line | w_err_line_set;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_row_base   <= w_base_nxt;
        end
    end

    assign s_ready    = r_s_ready;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_done = r_frame_done;
    assign err_sof    = r_err_sof;
    assign err_line   = r_err_line;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// ----------------------------------------------------------------------------
// tb_frame_buffer_writer
// Directed bench for frame_buffer_writer. Expected RAM writes are queued as
// beats are driven and compared by a monitor as the DUT issues them.
// ----------------------------------------------------------------------------
module tb_frame_buffer_writer;
    import frame_buffer_writer_pkg::*;

    logic              pixel_clk;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [PIX_W-1:0]  s_data;
    logic              s_sof;
    logic              s_eol;
    logic              frame_strb;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              rd_bank;
    logic              frame_done;
    logic              err_sof;
    logic              err_line;

    typedef struct packed {
        logic              bank;
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
        logic              done;
    } wr_t;

    wr_t sb[$];
    int  n_tests;
    int  n_fail;

    frame_buffer_writer dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .s_eol      (s_eol),
        .frame_strb (frame_strb),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_bank    (rd_bank),
        .frame_done (frame_done),
        .err_sof    (err_sof),
        .err_line   (err_line)
    );

    initial begin
        pixel_clk = 1'b0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PIX_W-1:0] pix(input logic [7:0] tag, input int y, input int x);
        return {tag, 8'(y), 8'(x)};
    endfunction

    task automatic exp_wr(input logic bank, input int y, input int x, input logic [7:0] tag,
                          input logic done);
        wr_t e;
        e.bank = bank;
        e.addr = ADDR_W'(y * 224 + x);
        e.data = pix(tag, y, x);
        e.done = done;
        sb.push_back(e);
    endtask

    // Drives one beat for one clock; returns at the following falling edge.
    task automatic beat(input logic [PIX_W-1:0] d, input logic sof, input logic eol,
                        input logic strb);
        s_valid    = 1'b1;
        s_data     = d;
        s_sof      = sof;
        s_eol      = eol;
        frame_strb = strb;
        @(posedge pixel_clk);
        @(negedge pixel_clk);
        s_valid    = 1'b0;
        s_sof      = 1'b0;
        s_eol      = 1'b0;
        frame_strb = 1'b0;
    endtask

    task automatic strobe();
        frame_strb = 1'b1;
        @(posedge pixel_clk);
        @(negedge pixel_clk);
        frame_strb = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(posedge pixel_clk);
        @(negedge pixel_clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_s_ready"},    64'(s_ready),    64'd1);
        check({pfx, "_wr_en"},      64'(wr_en),      64'd0);
        check({pfx, "_wr_addr"},    64'(wr_addr),    64'd0);
        check({pfx, "_wr_data"},    64'(wr_data),    64'd0);
        check({pfx, "_wr_bank"},    64'(wr_bank),    64'd1);
        check({pfx, "_rd_bank"},    64'(rd_bank),    64'd0);
        check({pfx, "_frame_done"}, 64'(frame_done), 64'd0);
        check({pfx, "_err_sof"},    64'(err_sof),    64'd0);
        check({pfx, "_err_line"},   64'(err_line),   64'd0);
    endtask

    // Compares every RAM write against the head of the scoreboard.
    task automatic monitor();
        wr_t e;
        forever begin
            @(negedge pixel_clk);
            if (wr_en === 1'b1) begin
                check("write_has_expectation", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("write", 64'({wr_bank, wr_addr, wr_data, frame_done}), 64'(e));
                end
            end else begin
                check("frame_done_without_write", 64'(frame_done), 64'd0);
            end
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        s_sof      = 1'b0;
        s_eol      = 1'b0;
        frame_strb = 1'b0;
        repeat (2) @(negedge pixel_clk);
        rst = 1'b0;
        fork
            monitor();
        join_none
        check_reset_outputs("reset");

        // Strobe while idle: no swap.
        strobe();
        check("idle_strb_wr_bank", 64'(wr_bank), 64'd1);
        check("idle_strb_rd_bank", 64'(rd_bank), 64'd0);

        // Ten non-SOF beats in IDLE are dropped (monitor flags any write).
        for (int i = 0; i < 10; i++) beat(pix(8'hEE, 0, i), 1'b0, 1'b0, 1'b0);

        // Full frame into bank 1; strobe coincides with the last pixel.
        for (int y = 0; y < 224; y++) begin
            for (int x = 0; x < 224; x++) begin
                exp_wr(1'b1, y, x, 8'h01, (y == 223) && (x == 223));
                beat(pix(8'h01, y, x), (y == 0) && (x == 0), x == 223,
                     (y == 223) && (x == 223));
            end
        end
        check("f1_s_ready_after_last", 64'(s_ready), 64'd0);
        check("f1_err_line", 64'(err_line), 64'd0);
        check("f1_err_sof", 64'(err_sof), 64'd0);
        // Beats offered while full are not accepted.
        for (int i = 0; i < 3; i++) beat(pix(8'hDD, 0, i), i == 0, 1'b0, 1'b0);
        check("f1_no_swap_wr_bank", 64'(wr_bank), 64'd1);
        check("f1_no_swap_rd_bank", 64'(rd_bank), 64'd0);
        check("f1_s_ready_held", 64'(s_ready), 64'd0);
        strobe();
        check("f1_swap_rd_bank", 64'(rd_bank), 64'd1);
        check("f1_swap_wr_bank", 64'(wr_bank), 64'd0);
        check("f1_s_ready_after_swap", 64'(s_ready), 64'd1);

        // Frame 2 into bank 0: lines 0..2 full, line 3 short (eol at x=99).
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 224; x++) begin
                exp_wr(1'b0, y, x, 8'h02, 1'b0);
                beat(pix(8'h02, y, x), (y == 0) && (x == 0), x == 223, 1'b0);
            end
        end
        check("f2_err_line_clean", 64'(err_line), 64'd0);
        for (int x = 0; x < 100; x++) begin
            exp_wr(1'b0, 3, x, 8'h02, 1'b0);
            beat(pix(8'h02, 3, x), 1'b0, x == 99, 1'b0);
        end
        check("f2_err_line_short", 64'(err_line), 64'd1);
        // Lines 4..222: one pixel each, first lands at 4*224 = 896.
        for (int y = 4; y < 223; y++) begin
            exp_wr(1'b0, y, 0, 8'h02, 1'b0);
            beat(pix(8'h02, y, 0), 1'b0, 1'b1, 1'b0);
        end
        for (int x = 0; x < 224; x++) begin
            exp_wr(1'b0, 223, x, 8'h02, x == 223);
            beat(pix(8'h02, 223, x), 1'b0, x == 223, 1'b0);
        end
        check("f2_s_ready_after_last", 64'(s_ready), 64'd0);
        check("f2_err_sof", 64'(err_sof), 64'd0);
        for (int i = 0; i < 3; i++) beat(pix(8'hCC, 0, i), i == 0, 1'b0, 1'b0);
        check("f2_wr_bank_held", 64'(wr_bank), 64'd0);
        check("f2_rd_bank_held", 64'(rd_bank), 64'd1);

        // Reset from FULL with swapped banks: everything back to reset values.
        reset_pulse();
        check_reset_outputs("rst_full");

        // Overlong line 0 (230 beats): 224 written, 6 dropped.
        for (int x = 0; x < 230; x++) begin
            if (x < 224) exp_wr(1'b1, 0, x, 8'h03, 1'b0);
            beat(pix(8'h03, 0, x), x == 0, x == 229, 1'b0);
        end
        check("long_err_line", 64'(err_line), 64'd1);
        check("long_err_sof", 64'(err_sof), 64'd0);
        for (int y = 1; y < 5; y++) begin
            for (int x = 0; x < 224; x++) begin
                exp_wr(1'b1, y, x, 8'h03, 1'b0);
                beat(pix(8'h03, y, x), 1'b0, x == 223, 1'b0);
            end
        end
        for (int x = 0; x < 17; x++) begin
            exp_wr(1'b1, 5, x, 8'h03, 1'b0);
            beat(pix(8'h03, 5, x), 1'b0, 1'b0, 1'b0);
        end
        // SOF at y=5, x=17 restarts at address 0.
        exp_wr(1'b1, 0, 0, 8'h04, 1'b0);
        beat(pix(8'h04, 0, 0), 1'b1, 1'b0, 1'b0);
        check("midsof_err_sof", 64'(err_sof), 64'd1);
        exp_wr(1'b1, 0, 1, 8'h04, 1'b0);
        beat(pix(8'h04, 0, 1), 1'b0, 1'b1, 1'b0);
        for (int y = 1; y < 100; y++) begin
            exp_wr(1'b1, y, 0, 8'h04, 1'b0);
            beat(pix(8'h04, y, 0), 1'b0, 1'b1, 1'b0);
        end
        for (int x = 0; x < 3; x++) begin
            exp_wr(1'b1, 100, x, 8'h04, 1'b0);
            beat(pix(8'h04, 100, x), 1'b0, 1'b0, 1'b0);
        end

        // Reset mid-frame at y=100, then a strobe must not swap.
        reset_pulse();
        check_reset_outputs("rst_mid");
        strobe();
        check("rst_mid_strb_wr_bank", 64'(wr_bank), 64'd1);
        check("rst_mid_strb_rd_bank", 64'(rd_bank), 64'd0);
        check("rst_mid_strb_s_ready", 64'(s_ready), 64'd1);

        repeat (3) @(negedge pixel_clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
